// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// Drives the select/enable inputs of a downstream 2-to-4 one-hot decoder.
module rr_arbiter_4 #(
   parameter int HOLD_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] i_req,
   input  logic       i_release,
   output logic [1:0] o_gnt_idx,
   output logic       o_gnt_en,
   output logic       o_timeout
);

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   logic [1:0]       r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_gnt_idx;
   logic             r_gnt_en;
   logic             r_timeout;

   logic             w_any;
   logic             w_end_rel;
   logic             w_end_wd;
   logic             w_end_to;
   logic             w_end;
   logic [1:0]       w_ptr_nxt;
   logic [1:0]       w_win_idle;
   logic [1:0]       w_win_end;

   // Lowest offset from ptr wins; scanning high-to-low lets it overwrite last.
   function automatic logic [1:0] f_pick(
      input logic [1:0] ptr,
      input logic [3:0] req
   );
      logic [1:0] idx;
      f_pick = ptr;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) f_pick = idx;
      end
   endfunction

   always_comb begin
      w_any      = |i_req;
      w_end_rel  = i_release;
      w_end_wd   = !i_req[r_gnt_idx];
      w_end_to   = (HOLD_MAX != 0) && (r_cnt == HOLD_LIM);
      w_end      = w_end_rel || w_end_wd || w_end_to;
      w_ptr_nxt  = r_gnt_idx + 2'd1;
      w_win_idle = f_pick(r_ptr, i_req);
      w_win_end  = f_pick(w_ptr_nxt, i_req);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ptr     <= 2'd0;
         r_cnt     <= '0;
         r_gnt_idx <= 2'd0;
         r_gnt_en  <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt_idx <= w_win_idle;
                  r_gnt_en  <= 1'b1;
                  r_cnt     <= CNT_ONE;
                  r_state   <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_end) begin
                  r_ptr     <= w_ptr_nxt;
                  // Only a pure hold expiry counts as a revocation.
                  r_timeout <= !w_end_rel && !w_end_wd && w_end_to;
                  if (w_any) begin
                     r_gnt_idx <= w_win_end;
                     r_cnt     <= CNT_ONE;
                  end else begin
                     r_gnt_en  <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end else if (r_cnt != '1) begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_gnt_idx = r_gnt_idx;
   assign o_gnt_en  = r_gnt_en;
   assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus a randomized run
// against an integer-level round-robin model.
module tb_rr_arbiter_4;

   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       rel;
   logic [1:0] gnt_idx;
   logic       gnt_en;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   int m_busy, m_idx, m_ptr, m_held, m_to;

   rr_arbiter_4 #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req),
      .i_release (rel),
      .o_gnt_idx (gnt_idx),
      .o_gnt_en  (gnt_en),
      .o_timeout (timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 4'b0;
      rel   = 1'b0;
      rst_n = 1'b0;
      #7;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int pick(input int ptr, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         if (r[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [3:0] r, input logic rl);
      int w;
      bit fin, exp;
      m_to = 0;
      if (m_busy == 0) begin
         w = pick(m_ptr, r);
         if (w >= 0) begin
            m_busy = 1;
            m_idx  = w;
            m_held = 1;
         end
      end else begin
         exp = (HOLD != 0) && (m_held >= HOLD);
         fin = rl || !r[m_idx] || exp;
         if (fin) begin
            m_to  = (!rl && r[m_idx] && exp) ? 1 : 0;
            m_ptr = (m_idx + 1) % 4;
            w = pick(m_ptr, r);
            if (w >= 0) begin
               m_idx  = w;
               m_held = 1;
            end else begin
               m_busy = 0;
            end
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic test_reset();
      req   = 4'b0;
      rel   = 1'b0;
      rst_n = 1'b0;
      #12;
      checks++;
      if (gnt_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_en got %b want 0", gnt_en);
      end
      checks++;
      if (gnt_idx !== 2'd0) begin
         errors++;
         $display("FAIL reset_idx got %0d want 0", gnt_idx);
      end
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset_to got %b want 0", timeout);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      req = 4'b0100;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 2'd2) begin
         errors++;
         $display("FAIL single_grant got en=%b idx=%0d want en=1 idx=2",
                  gnt_en, gnt_idx);
      end
      req = 4'b0;
      rel = 1'b1;
      tick();
      rel = 1'b0;
      checks++;
      if (gnt_en !== 1'b0 || gnt_idx !== 2'd2) begin
         errors++;
         $display("FAIL single_rel got en=%b idx=%0d want en=0 idx=2",
                  gnt_en, gnt_idx);
      end
   endtask

   task automatic test_wrap_skip();
      req = 4'b0011;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 2'd0) begin
         errors++;
         $display("FAIL wrap_first got en=%b idx=%0d want en=1 idx=0",
                  gnt_en, gnt_idx);
      end
      rel = 1'b1;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 2'd1) begin
         errors++;
         $display("FAIL wrap_second got en=%b idx=%0d want en=1 idx=1",
                  gnt_en, gnt_idx);
      end
      req = 4'b0;
      tick();
      rel = 1'b0;
   endtask

   task automatic test_rotation();
      do_reset();
      req = 4'b1111;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 2'd0) begin
         errors++;
         $display("FAIL rot_0 got en=%b idx=%0d want en=1 idx=0",
                  gnt_en, gnt_idx);
      end
      rel = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (gnt_en !== 1'b1 || gnt_idx !== 2'(k % 4)) begin
            errors++;
            $display("FAIL rot_%0d got en=%b idx=%0d want en=1 idx=%0d",
                     k, gnt_en, gnt_idx, k % 4);
         end
      end
      req = 4'b0;
      tick();
      rel = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < HOLD; k++) begin
         tick();
         checks++;
         if (gnt_idx !== 2'd0 || gnt_en !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_hold%0d got idx=%0d en=%b to=%b want 0/1/0",
                     k, gnt_idx, gnt_en, timeout);
         end
      end
      tick();
      checks++;
      if (timeout !== 1'b1 || gnt_idx !== 2'd1 || gnt_en !== 1'b1) begin
         errors++;
         $display("FAIL to_fire got to=%b idx=%0d en=%b want 1/1/1",
                  timeout, gnt_idx, gnt_en);
      end
      tick();
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL to_pulse got to=%b want 0", timeout);
      end
   endtask

   task automatic test_timeout_release();
      do_reset();
      req = 4'b0011;
      for (int k = 0; k < HOLD; k++) tick();
      rel = 1'b1;
      tick();
      rel = 1'b0;
      checks++;
      if (timeout !== 1'b0 || gnt_idx !== 2'd1 || gnt_en !== 1'b1) begin
         errors++;
         $display("FAIL to_rel got to=%b idx=%0d en=%b want 0/1/1",
                  timeout, gnt_idx, gnt_en);
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b1000;
      tick();
      checks++;
      if (gnt_idx !== 2'd3 || gnt_en !== 1'b1 || timeout !== 1'b0) begin
         errors++;
         $display("FAIL withdraw got idx=%0d en=%b to=%b want 3/1/0",
                  gnt_idx, gnt_en, timeout);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (gnt_en !== 1'b0 || gnt_idx !== 2'd0) begin
         errors++;
         $display("FAIL async_rst got en=%b idx=%0d want en=0 idx=0",
                  gnt_en, gnt_idx);
      end
      req = 4'b1000;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++;
      if (gnt_en !== 1'b1 || gnt_idx !== 2'd3) begin
         errors++;
         $display("FAIL async_regrant got en=%b idx=%0d want en=1 idx=3",
                  gnt_en, gnt_idx);
      end
   endtask

   task automatic test_random();
      do_reset();
      m_busy = 0;
      m_idx  = 0;
      m_ptr  = 0;
      m_held = 0;
      m_to   = 0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         rel = ($urandom_range(0, 5) == 0);
         @(posedge clk);
         model_step(req, rel);
         #1;
         checks++;
         if (gnt_en !== (m_busy != 0) || gnt_idx !== 2'(m_idx) ||
             timeout !== (m_to != 0)) begin
            errors++;
            $display("FAIL rand_c%0d got en=%b idx=%0d to=%b want %0d/%0d/%0d",
                     c, gnt_en, gnt_idx, timeout, m_busy, m_idx, m_to);
         end
      end
      req = 4'b0;
      rel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_skip();
      test_rotation();
      test_timeout();
      test_timeout_release();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that produces a 2-bit grant index plus grant-enable.
- Its outputs drive the select/enable inputs of the 2-to-4 one-hot decoder directly downstream. The decoder turns them into one-hot grant lines.
- Adds fairness (rotating priority) and a bounded hold time per grant.

Parameters:
- HOLD_MAX, 8: maximum consecutive cycles one grant may be held. 0 = unlimited.
- CNT_W, 4: width of hold counter. Must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 4: req[i] = requester i wants ownership. Level-sensitive.
- release, input, 1: current owner finished. Sampled only in GRANT.
- gnt_idx, output, 2: index of current owner. Feeds decoder select.
- gnt_en, output, 1: a grant is active. Feeds decoder enable.
- timeout, output, 1: one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, gnt_idx=0, gnt_en=0, timeout=0, ptr=0, hold_cnt=0.
  - Takes effect immediately, including mid-grant: gnt_en drops without waiting for clk.
- All outputs are registered. No combinational path from inputs to outputs.
- Priority search: from ptr upward modulo 4 (ptr, ptr+1, ptr+2, ptr+3). The first asserted req bit wins.
- States: IDLE, GRANT.
- IDLE:
  - If req != 0 at a clock edge, at that edge: gnt_idx <= winner, gnt_en <= 1, hold_cnt <= 1, state <= GRANT.
  - Latency: req high before edge k means gnt_en is high after edge k.
  - release is ignored in IDLE.
- GRANT, end conditions, evaluated each edge in priority order:
  1. release=1.
  2. req[gnt_idx]=0 (owner withdrew).
  3. HOLD_MAX!=0 and hold_cnt==HOLD_MAX. This is the only case that sets timeout<=1 for one cycle.
- GRANT, no end condition: hold_cnt <= hold_cnt+1, saturating at all-ones. gnt_idx and gnt_en are unchanged.
- GRANT, on end:
  - ptr <= gnt_idx+1 (mod 4). The finished owner becomes lowest priority.
  - The search for the next grant uses the new ptr and current req.
  - If req != 0: gnt_idx <= new winner, gnt_en stays 1, hold_cnt <= 1, state stays GRANT. No idle bubble.
  - A lone owner still requesting is regranted the same index with a fresh hold window.
  - If req == 0: gnt_en <= 0, state <= IDLE, gnt_idx keeps its last value.
- Simultaneous release and hold expiry: treated as release, so no timeout pulse.
- Owner dropping req and asserting release in the same cycle: single end event, pointer advanced once.
- gnt_idx is don't-care to the downstream stage when gnt_en=0, but must hold its previous value (no toggling).
- Invariant: gnt_en=1 implies the requester at gnt_idx had req high at the edge it was granted.
- Pointer wrap: gnt_idx=3 on end gives ptr=0.

Test Plan:
- Reset then single request: rst_n low, then high; req=4'b0100 → one edge later gnt_idx=2, gnt_en=1. Release at the next edge with req=0 → gnt_en=0, gnt_idx stays 2.
- Rotation: req=4'b1111 held, release pulsed once per grant → gnt_idx sequence 0,1,2,3,0. gnt_en continuously 1 with no bubble.
- Wrap and skip: ptr=3 (after a grant to 2); req=4'b0011 → grant 0, then after release grant 1.
- Timeout: HOLD_MAX=4; req=4'b0001 and 4'b0010 set, no release → idx 0 for 4 cycles, timeout pulses one cycle, then gnt_idx=1. Repeat with release asserted on cycle 4 → same handoff, timeout stays 0.
- Owner withdraw: grant to 1, then drop req[1] with req[3]=1 → next edge gnt_idx=3, timeout=0.
- Async reset mid-grant: gnt_en=1, idx=2; assert rst_n low between edges → gnt_en=0 and gnt_idx=0 immediately. After release of reset with req=4'b1000 → grant 3 at the first edge.
